// File: rtl/zion_clr_en_pipe_pkg.sv
// Shared helpers for zion_clr_en_pipe: occupancy-counter width and the
// input-to-output data width conversion.
package zion_clr_en_pipe_pkg;

   localparam int MAX_W = 256;

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Keeps the low w_in bits and zero-fills above; the caller narrows the result.
   function automatic logic [MAX_W-1:0] fit_width(input logic [MAX_W-1:0] din,
                                                  input int w_in);
      logic [MAX_W-1:0] dout;
      dout = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < w_in) dout[i] = din[i];
      end
      return dout;
   endfunction

endpackage

// File: rtl/zion_clr_en_pipe_stage.sv
// One pipeline stage: valid bit plus data register with enable, flush and
// INI_DATA reset value. Flush wins over enable.
module zion_clr_en_pipe_stage #(
   parameter int            W        = 32,
   parameter logic [W-1:0]  INI_DATA = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic          vld_i,
   input  logic [W-1:0]  dat_i,
   output logic          vld_o,
   output logic [W-1:0]  dat_o
);

   logic          vld_q, vld_d;
   logic [W-1:0]  dat_q, dat_d;

   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (clr) begin
         vld_d = 1'b0;
         dat_d = INI_DATA;
      end else if (en) begin
         vld_d = vld_i;
         // a bubble moves in without disturbing the held data
         if (vld_i) dat_d = dat_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_q <= 1'b0;
         dat_q <= INI_DATA;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   assign vld_o = vld_q;
   assign dat_o = dat_q;

endmodule

// File: rtl/zion_clr_en_pipe.sv
// DEPTH-stage bubble-collapsing valid/ready pipeline with synchronous flush.
// Define ZION_CLR_EN_PIPE_CNT_EN to add the registered occupancy count oCnt.
module zion_clr_en_pipe
   import zion_clr_en_pipe_pkg::*;
#(
   parameter int                    WIDTH_IN  = 32,
   parameter int                    WIDTH_OUT = 32,
   parameter int                    DEPTH     = 2,
   parameter logic [WIDTH_OUT-1:0]  INI_DATA  = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  iClr,
   input  logic                  iVld,
   output logic                  oRdy,
   input  logic [WIDTH_IN-1:0]   iDat,
   output logic                  oVld,
   input  logic                  iRdy,
   output logic [WIDTH_OUT-1:0]  oDat
`ifdef ZION_CLR_EN_PIPE_CNT_EN
   ,
   output logic [cnt_width(DEPTH)-1:0] oCnt
`endif
);

   if (DEPTH < 1 || WIDTH_IN > MAX_W || WIDTH_OUT > MAX_W) begin : g_bad_cfg
      $error("zion_clr_en_pipe: DEPTH must be >= 1 and widths <= MAX_W");
   end

   logic [WIDTH_OUT-1:0]  din_conv;
   logic [DEPTH-1:0]      stg_vld;
   logic [DEPTH-1:0]      stg_adv;
   logic [DEPTH-1:0]      stg_en;
   logic [WIDTH_OUT-1:0]  stg_dat [DEPTH];

   assign din_conv = WIDTH_OUT'(fit_width(MAX_W'(iDat), WIDTH_IN));

   // Ready ripples back from the output: a stage moves on if the next one is
   // empty or itself moving, so any empty stage lets upstream beats close up.
   always_comb begin
      stg_adv = '0;
      stg_adv[DEPTH-1] = iRdy;
      for (int s = DEPTH - 2; s >= 0; s--) begin
         stg_adv[s] = !stg_vld[s+1] || stg_adv[s+1];
      end
      stg_en = ~stg_vld | stg_adv;
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            zion_clr_en_pipe_stage #(
               .W        (WIDTH_OUT),
               .INI_DATA (INI_DATA)
            ) u_stage (
               .clk   (clk),
               .rst   (rst),
               .clr   (iClr),
               .en    (stg_en[gi]),
               .vld_i (iVld),
               .dat_i (din_conv),
               .vld_o (stg_vld[gi]),
               .dat_o (stg_dat[gi])
            );
         end else begin : g_rest
            zion_clr_en_pipe_stage #(
               .W        (WIDTH_OUT),
               .INI_DATA (INI_DATA)
            ) u_stage (
               .clk   (clk),
               .rst   (rst),
               .clr   (iClr),
               .en    (stg_en[gi]),
               .vld_i (stg_vld[gi-1]),
               .dat_i (stg_dat[gi-1]),
               .vld_o (stg_vld[gi]),
               .dat_o (stg_dat[gi])
            );
         end
      end
   endgenerate

   assign oRdy = stg_en[0] && !iClr;
   assign oVld = stg_vld[DEPTH-1];
   assign oDat = stg_dat[DEPTH-1];

`ifdef ZION_CLR_EN_PIPE_CNT_EN
   localparam int CW = cnt_width(DEPTH);

   logic           in_xfer;
   logic           out_xfer;
   logic [CW-1:0]  cnt_q, cnt_d;

   assign in_xfer  = iVld && oRdy;
   assign out_xfer = oVld && iRdy;

   always_comb begin
      cnt_d = cnt_q;
      if (iClr) begin
         cnt_d = '0;
      end else if (in_xfer && !out_xfer) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!in_xfer && out_xfer) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign oCnt = cnt_q;
`endif

endmodule

// File: tb/tb_zion_clr_en_pipe.sv
// Self-checking bench for zion_clr_en_pipe: directed scenarios on several
// configurations plus a randomized run against a FIFO-queue reference model.
module tb_zion_clr_en_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   checks   = 0;
   int   failures = 0;

   localparam int DEPTH_A = 2;

   // A: DEPTH=2, 32->32, INI_DATA=1
   logic a_clr, a_vld, a_rdy, a_ovld, a_irdy;
   logic [31:0] a_dat, a_odat;
   // B: DEPTH=3, 32->32, INI_DATA=0
   logic b_clr, b_vld, b_rdy, b_ovld, b_irdy;
   logic [31:0] b_dat, b_odat;
   // C: DEPTH=2, 8->16
   logic c_clr, c_vld, c_rdy, c_ovld, c_irdy;
   logic [7:0]  c_dat;
   logic [15:0] c_odat;
   // D: DEPTH=1, 16->8
   logic d_clr, d_vld, d_rdy, d_ovld, d_irdy;
   logic [15:0] d_dat;
   logic [7:0]  d_odat;
`ifdef ZION_CLR_EN_PIPE_CNT_EN
   logic [1:0] a_cnt, b_cnt, c_cnt;
   logic [0:0] d_cnt;
`endif

   zion_clr_en_pipe #(.WIDTH_IN(32), .WIDTH_OUT(32), .DEPTH(DEPTH_A), .INI_DATA(32'h1)) u_a (
      .clk(clk), .rst(rst), .iClr(a_clr), .iVld(a_vld), .oRdy(a_rdy), .iDat(a_dat),
      .oVld(a_ovld), .iRdy(a_irdy), .oDat(a_odat)
`ifdef ZION_CLR_EN_PIPE_CNT_EN
      , .oCnt(a_cnt)
`endif
   );

   zion_clr_en_pipe #(.WIDTH_IN(32), .WIDTH_OUT(32), .DEPTH(3), .INI_DATA(32'h0)) u_b (
      .clk(clk), .rst(rst), .iClr(b_clr), .iVld(b_vld), .oRdy(b_rdy), .iDat(b_dat),
      .oVld(b_ovld), .iRdy(b_irdy), .oDat(b_odat)
`ifdef ZION_CLR_EN_PIPE_CNT_EN
      , .oCnt(b_cnt)
`endif
   );

   zion_clr_en_pipe #(.WIDTH_IN(8), .WIDTH_OUT(16), .DEPTH(2), .INI_DATA(16'h0)) u_c (
      .clk(clk), .rst(rst), .iClr(c_clr), .iVld(c_vld), .oRdy(c_rdy), .iDat(c_dat),
      .oVld(c_ovld), .iRdy(c_irdy), .oDat(c_odat)
`ifdef ZION_CLR_EN_PIPE_CNT_EN
      , .oCnt(c_cnt)
`endif
   );

   zion_clr_en_pipe #(.WIDTH_IN(16), .WIDTH_OUT(8), .DEPTH(1), .INI_DATA(8'h0)) u_d (
      .clk(clk), .rst(rst), .iClr(d_clr), .iVld(d_vld), .oRdy(d_rdy), .iDat(d_dat),
      .oVld(d_ovld), .iRdy(d_irdy), .oDat(d_odat)
`ifdef ZION_CLR_EN_PIPE_CNT_EN
      , .oCnt(d_cnt)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      a_clr = 0; a_vld = 0; a_irdy = 0; a_dat = '0;
      b_clr = 0; b_vld = 0; b_irdy = 0; b_dat = '0;
      c_clr = 0; c_vld = 0; c_irdy = 0; c_dat = '0;
      d_clr = 0; d_vld = 0; d_irdy = 0; d_dat = '0;
      tick();
      tick();
      checks++;
      if (a_odat !== 32'h1) begin
         failures++; $display("FAIL reset_hold_odat: got %h want 00000001", a_odat);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (a_ovld !== 1'b0) begin
         failures++; $display("FAIL reset_ovld: got %b want 0", a_ovld);
      end
      checks++;
      if (a_odat !== 32'h1) begin
         failures++; $display("FAIL reset_odat: got %h want 00000001", a_odat);
      end
      checks++;
      if (a_rdy !== 1'b1) begin
         failures++; $display("FAIL reset_ordy: got %b want 1", a_rdy);
      end
      checks++;
      if (b_odat !== 32'h0 || b_ovld !== 1'b0) begin
         failures++; $display("FAIL reset_b: got vld=%b dat=%h want vld=0 dat=0", b_ovld, b_odat);
      end
      checks++;
      if (d_rdy !== 1'b1) begin
         failures++; $display("FAIL reset_d_ordy: got %b want 1", d_rdy);
      end
`ifdef ZION_CLR_EN_PIPE_CNT_EN
      checks++;
      if (a_cnt !== 2'd0) begin
         failures++; $display("FAIL reset_ocnt: got %0d want 0", a_cnt);
      end
`endif
   endtask

   // DEPTH=3: beats 1..4 presented in cycles 0..3 appear in cycles 3..6
   task automatic test_streaming();
      logic exp_v;
      b_irdy = 1'b1;
      for (int cyc = 0; cyc < 8; cyc++) begin
         b_vld = (cyc < 4);
         b_dat = 32'(cyc + 1);
         #1;
         if (cyc < 4) begin
            checks++;
            if (b_rdy !== 1'b1) begin
               failures++; $display("FAIL stream_ordy cyc%0d: got %b want 1", cyc, b_rdy);
            end
         end
         exp_v = (cyc >= 3 && cyc <= 6);
         checks++;
         if (b_ovld !== exp_v) begin
            failures++; $display("FAIL stream_ovld cyc%0d: got %b want %b", cyc, b_ovld, exp_v);
         end
         if (exp_v) begin
            checks++;
            if (b_odat !== 32'(cyc - 2)) begin
               failures++; $display("FAIL stream_odat cyc%0d: got %h want %h", cyc, b_odat, 32'(cyc - 2));
            end
         end
         tick();
      end
      b_vld = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_q [3];
      int          nrecv;
      logic        accepted;
      exp_q[0] = 32'hA; exp_q[1] = 32'hB; exp_q[2] = 32'hC;
      a_irdy = 1'b0;
      for (int k = 0; k < 2; k++) begin
         a_vld = 1'b1; a_dat = exp_q[k];
         #1;
         checks++;
         if (a_rdy !== 1'b1) begin
            failures++; $display("FAIL bp_accept%0d: got ordy=%b want 1", k, a_rdy);
         end
         tick();
      end
      a_dat = exp_q[2];
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (a_rdy !== 1'b0) begin
            failures++; $display("FAIL bp_full_ordy%0d: got %b want 0", k, a_rdy);
         end
         checks++;
         if (a_ovld !== 1'b1 || a_odat !== 32'hA) begin
            failures++; $display("FAIL bp_stall%0d: got vld=%b dat=%h want vld=1 dat=0000000a", k, a_ovld, a_odat);
         end
`ifdef ZION_CLR_EN_PIPE_CNT_EN
         checks++;
         if (a_cnt !== 2'd2) begin
            failures++; $display("FAIL bp_ocnt%0d: got %0d want 2", k, a_cnt);
         end
`endif
         tick();
      end
      a_irdy = 1'b1;
      #1;
      checks++;
      if (a_rdy !== 1'b1) begin
         failures++; $display("FAIL bp_ready_rise: got %b want 1", a_rdy);
      end
      nrecv = 0;
      for (int cyc = 0; cyc < 12 && nrecv < 3; cyc++) begin
         if (a_ovld) begin
            checks++;
            if (a_odat !== exp_q[nrecv]) begin
               failures++; $display("FAIL bp_order%0d: got %h want %h", nrecv, a_odat, exp_q[nrecv]);
            end
            nrecv++;
         end
         accepted = a_vld && a_rdy;
         tick();
         if (accepted) a_vld = 1'b0;
         #1;
      end
      checks++;
      if (nrecv != 3) begin
         failures++; $display("FAIL bp_delivered: got %0d beats want 3", nrecv);
      end
      a_vld = 1'b0;
   endtask

   task automatic test_clear();
      a_irdy = 1'b0;
      for (int k = 0; k < 2; k++) begin
         a_vld = 1'b1; a_dat = 32'h11 * (k + 1);
         #1;
         checks++;
         if (a_rdy !== 1'b1) begin
            failures++; $display("FAIL clr_fill%0d: got ordy=%b want 1", k, a_rdy);
         end
         tick();
      end
      a_clr = 1'b1; a_vld = 1'b1; a_dat = 32'h33; a_irdy = 1'b1;
      #1;
      checks++;
      if (a_rdy !== 1'b0) begin
         failures++; $display("FAIL clr_ordy: got %b want 0", a_rdy);
      end
      tick();
      a_clr = 1'b0; a_vld = 1'b0;
      #1;
      checks++;
      if (a_ovld !== 1'b0 || a_odat !== 32'h1) begin
         failures++; $display("FAIL clr_after: got vld=%b dat=%h want vld=0 dat=00000001", a_ovld, a_odat);
      end
      checks++;
      if (a_rdy !== 1'b1) begin
         failures++; $display("FAIL clr_after_ordy: got %b want 1", a_rdy);
      end
`ifdef ZION_CLR_EN_PIPE_CNT_EN
      checks++;
      if (a_cnt !== 2'd0) begin
         failures++; $display("FAIL clr_ocnt: got %0d want 0", a_cnt);
      end
`endif
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (a_ovld !== 1'b0) begin
            failures++; $display("FAIL clr_no_leak%0d: got ovld=%b dat=%h want ovld=0", k, a_ovld, a_odat);
         end
      end
   endtask

   task automatic test_width();
      logic [7:0]  cv [4];
      logic [15:0] dv [4];
      logic [15:0] cq [$];
      logic [7:0]  dq [$];
      logic        exp_dv;
      int          cr, dr;
      cv[0] = 8'hF5;
      dv[0] = 16'h12F5;
      for (int k = 1; k < 4; k++) begin
         cv[k] = 8'($urandom);
         dv[k] = 16'($urandom);
      end
      cr = 0; dr = 0;
      c_irdy = 1'b1; d_irdy = 1'b1;
      for (int cyc = 0; cyc < 8; cyc++) begin
         if (cyc < 4) begin
            c_vld = 1'b1; c_dat = cv[cyc];
            d_vld = 1'b1; d_dat = dv[cyc];
         end else begin
            c_vld = 1'b0; d_vld = 1'b0;
         end
         #1;
         if (c_ovld) begin
            checks++;
            if (cq.size() == 0 || c_odat !== cq[0]) begin
               failures++; $display("FAIL width_ext%0d: got %h want %h", cr, c_odat, (cq.size() != 0) ? cq[0] : 16'hxxxx);
            end
            if (cq.size() != 0) void'(cq.pop_front());
            cr++;
         end
         exp_dv = (cyc >= 1 && cyc <= 4);
         checks++;
         if (d_ovld !== exp_dv) begin
            failures++; $display("FAIL width_depth1_ovld cyc%0d: got %b want %b", cyc, d_ovld, exp_dv);
         end
         if (d_ovld) begin
            checks++;
            if (dq.size() == 0 || d_odat !== dq[0]) begin
               failures++; $display("FAIL width_trunc%0d: got %h want %h", dr, d_odat, (dq.size() != 0) ? dq[0] : 8'hxx);
            end
            if (dq.size() != 0) void'(dq.pop_front());
            dr++;
         end
         if (c_vld && c_rdy) cq.push_back({8'h00, c_dat});
         if (d_vld && d_rdy) dq.push_back(d_dat[7:0]);
         tick();
      end
      checks++;
      if (cr != 4 || dr != 4) begin
         failures++; $display("FAIL width_count: got c=%0d d=%0d want 4 and 4", cr, dr);
      end
   endtask

   task automatic test_random();
      logic [31:0] q [$];
      logic        exp_rdy, stall_prev;
      logic [31:0] held;
      int          rdy_pct;
      a_clr = 1'b1; a_vld = 1'b0; a_irdy = 1'b0;
      tick();
      a_clr = 1'b0;
      stall_prev = 1'b0;
      held = '0;
      rdy_pct = 50;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         if (cyc % 500 == 0) rdy_pct = $urandom_range(10, 100);
         a_vld  = 1'($urandom_range(0, 1));
         a_dat  = $urandom;
         a_irdy = ($urandom_range(1, 100) <= rdy_pct);
         a_clr  = ($urandom_range(0, 63) == 0);
         #1;
         exp_rdy = (q.size() < DEPTH_A || a_irdy) && !a_clr;
         checks++;
         if (a_rdy !== exp_rdy) begin
            failures++; $display("FAIL rand_ordy cyc%0d: got %b want %b", cyc, a_rdy, exp_rdy);
         end
         if (stall_prev) begin
            checks++;
            if (a_ovld !== 1'b1 || a_odat !== held) begin
               failures++; $display("FAIL rand_stall cyc%0d: got vld=%b dat=%h want vld=1 dat=%h", cyc, a_ovld, a_odat, held);
            end
         end
         if (a_ovld) begin
            checks++;
            if (q.size() == 0) begin
               failures++; $display("FAIL rand_spurious cyc%0d: got ovld=1 dat=%h want no beat", cyc, a_odat);
            end else if (a_irdy) begin
               if (a_odat !== q[0]) begin
                  failures++; $display("FAIL rand_data cyc%0d: got %h want %h", cyc, a_odat, q[0]);
               end
               void'(q.pop_front());
            end
         end
         if (a_vld && exp_rdy) q.push_back(a_dat);
         if (a_clr) q.delete();
         stall_prev = a_ovld && !a_irdy && !a_clr;
         held = a_odat;
         tick();
`ifdef ZION_CLR_EN_PIPE_CNT_EN
         checks++;
         if (32'(a_cnt) != q.size()) begin
            failures++; $display("FAIL rand_ocnt cyc%0d: got %0d want %0d", cyc, a_cnt, q.size());
         end
`endif
      end
      a_vld = 1'b0; a_clr = 1'b0; a_irdy = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         if (a_ovld && q.size() != 0) begin
            checks++;
            if (a_odat !== q[0]) begin
               failures++; $display("FAIL rand_drain: got %h want %h", a_odat, q[0]);
            end
            void'(q.pop_front());
         end
         tick();
      end
      checks++;
      if (q.size() != 0) begin
         failures++; $display("FAIL rand_drain_left: got %0d undelivered beats want 0", q.size());
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_clear();
      test_width();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
